// File: rtl/pixel_readout_capture.sv
// Pixel row readout capture: strobe-qualified DATA sampling into a small FIFO.
// Define PIXEL_READOUT_ROWCHK_EN to also flag out-of-order row samples on strobe_err.
module pixel_readout_capture #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read1,
    input  logic       read2,
    input  logic       read3,
    input  logic       read4,
    input  logic       convert,
    input  logic [7:0] DATA,
    output logic [7:0] out_data,
    output logic [1:0] out_row,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       overflow,
    output logic       strobe_err
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] FifoFull   = CntW'(FIFO_DEPTH);
    localparam logic [3:0]      SettleLast = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StHold} state_e;

    state_e          state_q, state_d;
    logic [1:0]      row_q, row_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [9:0]      mem_d [FIFO_DEPTH];
    logic            convert_q;
    logic            wait_low_q, wait_low_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;
    logic            strobe_err_q, strobe_err_d;

    logic [3:0] reads;
    logic [1:0] strobe_row;
    logic       any_high, one_hot, conv_rise;
    logic       push, multi, pop, push_ok, row_err;
    logic [9:0] head;

    assign reads     = {read4, read3, read2, read1};
    assign any_high  = |reads;
    assign one_hot   = any_high && ((reads & (reads - 4'd1)) == 4'd0);
    assign conv_rise = convert && !convert_q;

    always_comb begin
        strobe_row = 2'd0;
        case (reads)
            4'b0010: strobe_row = 2'd1;
            4'b0100: strobe_row = 2'd2;
            4'b1000: strobe_row = 2'd3;
            default: strobe_row = 2'd0;
        endcase
    end

    // A strobe held across reset must fall before it can start a new capture.
    assign wait_low_d = wait_low_q && any_high;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        multi   = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_high && !one_hot) begin
                    multi = 1'b1;
                end else if (one_hot && !wait_low_q) begin
                    row_d   = strobe_row;
                    cnt_d   = 4'd0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!reads[row_q]) begin
                    state_d = StIdle;
                end else if (cnt_q == SettleLast) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                push    = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (!any_high) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop     = out_valid && out_ready;
    assign push_ok = push && ((count_q != FifoFull) || pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
        count_d  = count_q + CntW'(push_ok) - CntW'(pop);
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = {row_q, DATA};
    end

`ifdef PIXEL_READOUT_ROWCHK_EN
    logic [1:0] exp_row_q, exp_row_d, exp_row_eff;

    always_comb begin
        exp_row_eff = conv_rise ? 2'd0 : exp_row_q;
        exp_row_d   = exp_row_eff;
        row_err     = 1'b0;
        if (push) begin
            row_err   = (row_q != exp_row_eff);
            exp_row_d = exp_row_eff + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) exp_row_q <= 2'd0;
        else       exp_row_q <= exp_row_d;
    end
`else
    assign row_err = 1'b0;
`endif

    // A new event in the same cycle as a convert rise still sets its flag.
    always_comb begin
        overflow_d   = (overflow_q && !conv_rise) || (push && !push_ok);
        strobe_err_d = (strobe_err_q && !conv_rise) || multi || row_err;
        frame_done_d = push && (row_q == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            row_q        <= 2'd0;
            cnt_q        <= 4'd0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            convert_q    <= 1'b0;
            wait_low_q   <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            strobe_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            convert_q    <= convert;
            wait_low_q   <= wait_low_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            strobe_err_q <= strobe_err_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? head[7:0] : 8'd0;
    assign out_row    = out_valid ? head[9:8] : 2'd0;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign strobe_err = strobe_err_q;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Self-checking bench for pixel_readout_capture: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_pixel_readout_capture;
    localparam int S = 2;
    localparam int D = 4;
`ifdef PIXEL_READOUT_ROWCHK_EN
    localparam bit RowChk = 1'b1;
`else
    localparam bit RowChk = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       read1 = 1'b0, read2 = 1'b0, read3 = 1'b0, read4 = 1'b0;
    logic       convert = 1'b0;
    logic [7:0] DATA = 8'd0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] out_row;
    logic       out_valid, frame_done, overflow, strobe_err;

    int n_vec = 0;
    int n_bad = 0;

    pixel_readout_capture #(.SETTLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .read1(read1), .read2(read2), .read3(read3),
        .read4(read4), .convert(convert), .DATA(DATA), .out_data(out_data),
        .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
        .frame_done(frame_done), .overflow(overflow), .strobe_err(strobe_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] reads;
        int         len;
        logic [7:0] data;
        bit         push;
        bit         err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reads(input logic [3:0] r);
        {read4, read3, read2, read1} = r;
    endtask

    task automatic conv_pulse();
        convert = 1'b1;
        tick();
        convert = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic [3:0] r, input logic [7:0] d, input int len, input int gap);
        DATA = d;
        set_reads(r);
        repeat (len) tick();
        set_reads(4'd0);
        repeat (gap) tick();
    endtask

    initial begin
        logic [9:0] mq [$];
        logic [9:0] got;
        bit         m_ovf;
        bit         fd_exp;
        int         saw;

        tbl[0] = '{4'b0001, 4, 8'h11, 1'b1, 1'b0};
        tbl[1] = '{4'b0010, 4, 8'h22, 1'b1, 1'b0};
        tbl[2] = '{4'b0100, 4, 8'h33, 1'b1, 1'b0};
        tbl[3] = '{4'b1000, 4, 8'h44, 1'b1, 1'b0};
        tbl[4] = '{4'b0001, 1, 8'h55, 1'b0, 1'b0};
        tbl[5] = '{4'b0001, 2, 8'h66, 1'b0, 1'b0};
        tbl[6] = '{4'b0001, 3, 8'h77, 1'b1, 1'b0};
        tbl[7] = '{4'b0110, 4, 8'h88, 1'b0, 1'b1};
        tbl[8] = '{4'b1001, 3, 8'h99, 1'b0, 1'b1};
        tbl[9] = '{4'b1000, 6, 8'hAA, 1'b1, 1'b0};

        // Reset state
        repeat (2) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_strobe_err", 32'(strobe_err), 32'd0);
        chk("rst_head", 32'({out_row, out_data}), 32'd0);
        reset = 1'b0;
        tick();

        // Vector table: one strobe pattern per record, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int beats, fd, row;
            bit exp_err;
            beats = 0;
            fd = 0;
            row = 0;
            got = '0;
            for (int j = 0; j < 4; j++) if (tbl[i].reads[j]) row = j;
            exp_err = tbl[i].err || (RowChk && tbl[i].push && row != 0);
            DATA = tbl[i].data;
            set_reads(tbl[i].reads);
            for (int c = 0; c < tbl[i].len + 6; c++) begin
                if (c == tbl[i].len) set_reads(4'd0);
                tick();
                if (out_valid) begin
                    beats++;
                    got = {out_row, out_data};
                end
                if (frame_done) fd++;
            end
            chk($sformatf("tbl%0d_beats", i), 32'(beats), 32'(tbl[i].push));
            if (tbl[i].push) chk($sformatf("tbl%0d_head", i), 32'(got), 32'({2'(row), tbl[i].data}));
            chk($sformatf("tbl%0d_frame_done", i), 32'(fd), 32'(tbl[i].push && row == 3));
            chk($sformatf("tbl%0d_strobe_err", i), 32'(strobe_err), 32'(exp_err));
            conv_pulse();
            chk($sformatf("tbl%0d_err_clr", i), 32'(strobe_err), 32'd0);
        end

        // Overflow with a stalled consumer; head stays put
        out_ready = 1'b0;
        strobe(4'b0001, 8'hA0, 4, 3);
        for (int k = 1; k < 5; k++) begin
            strobe(4'(1 << (k % 4)), 8'hA0 + 8'(k), 4, 3);
            chk($sformatf("ovf_hold%0d", k), 32'({out_row, out_data}), 32'({2'd0, 8'hA0}));
        end
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_pop%0d", k), 32'({out_row, out_data}), 32'({2'(k), 8'hA0 + 8'(k)}));
            tick();
        end
        chk("ovf_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        conv_pulse();
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with a pop in the sample cycle accepts the push
        for (int k = 0; k < 4; k++) strobe(4'(1 << k), 8'hB0 + 8'(k), 4, 3);
        DATA = 8'hB4;
        set_reads(4'b0001);
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_reads(4'd0);
        repeat (2) tick();
        chk("full_pop_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("full_pop_head%0d", k), 32'({out_row, out_data}),
                32'({2'(k % 4), 8'hB0 + 8'(k)}));
            tick();
        end
        chk("full_pop_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset mid-capture, strobe held across release
        strobe(4'b0001, 8'hC0, 4, 3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        set_reads(4'b0001);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_head", 32'({out_row, out_data}), 32'd0);
        tick();
        reset = 1'b0;
        saw = 0;
        repeat (6) begin
            tick();
            if (out_valid) saw++;
        end
        chk("held_strobe_no_push", 32'(saw), 32'd0);
        set_reads(4'd0);
        repeat (2) tick();
        strobe(4'b0001, 8'hC5, 4, 3);
        chk("rearm_head", 32'({out_valid, out_row, out_data}), 32'({1'b1, 2'd0, 8'hC5}));
        out_ready = 1'b1;
        tick();
        chk("rearm_empty", 32'(out_valid), 32'd0);

`ifdef PIXEL_READOUT_ROWCHK_EN
        conv_pulse();
        strobe(4'b0001, 8'hD0, 4, 3);
        chk("rowchk_in_order", 32'(strobe_err), 32'd0);
        strobe(4'b0100, 8'hD2, 4, 3);
        chk("rowchk_skip", 32'(strobe_err), 32'd1);
        chk("rowchk_pushed", 32'(out_valid), 32'd0);
`endif

        // Randomized single-strobe traffic against a queue model
        conv_pulse();
        m_ovf = 1'b0;
        fd_exp = 1'b0;
        for (int p = 0; p < 60; p++) begin
            int r, len, gap, stall;
            r = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            gap = $urandom_range(2, 4);
            stall = $urandom_range(0, 3);
            DATA = 8'($urandom);
            set_reads(4'(1 << r));
            for (int k = 1; k <= len + gap; k++) begin
                bit pop, push;
                if (k == len + 1) set_reads(4'd0);
                out_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, stall) == 0);
                chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
                if (mq.size() != 0) chk("rnd_head", 32'({out_row, out_data}), 32'(mq[0]));
                chk("rnd_frame_done", 32'(frame_done), 32'(fd_exp));
                chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
`ifndef PIXEL_READOUT_ROWCHK_EN
                chk("rnd_strobe_err", 32'(strobe_err), 32'd0);
`endif
                // Sample lands on the (S+2)th edge after the strobe rises.
                pop = (mq.size() != 0) && out_ready;
                push = (len >= S + 1) && (k == S + 2);
                fd_exp = push && (r == 3);
                if (push) begin
                    if (mq.size() < D || pop) mq.push_back({2'(r), DATA});
                    else m_ovf = 1'b1;
                end
                if (pop) void'(mq.pop_front());
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pixel_readout_capture.md
PIXEL_READOUT_CAPTURE -- requirements
Module: pixel_readout_capture

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the cycles from read-strobe rise to the DATA sample (legal range 1..15).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the capture FIFO entry count (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have ports read1, read2, read3, read4, each input, 1 bit: row read strobes from the pixel sensor FSM.
REQ-006 The block SHALL have port convert, input, 1 bit: conversion phase marker; its rising edge starts a new frame.
REQ-007 The block SHALL have port DATA, input, 8 bits: the shared pixel data bus.
REQ-008 The block SHALL have port out_data, output, 8 bits: the captured pixel value at the FIFO head.
REQ-009 The block SHALL have port out_row, output, 2 bits: the row index (0..3) of out_data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the row-4 sample is written.
REQ-013 The block SHALL have ports overflow and strobe_err, each output, 1 bit: sticky error flags.

Function
REQ-014 The capture FSM SHALL have the states IDLE, SETTLE, SAMPLE and HOLD.
REQ-015 In IDLE, when exactly one readN is high, the FSM SHALL latch row index N-1, clear the settle counter and go to SETTLE.
REQ-016 In SETTLE, the FSM SHALL increment the counter each cycle and go to SAMPLE on the cycle the counter reaches SETTLE_CYCLES-1.
REQ-017 In SAMPLE, the FSM SHALL push {row, DATA} into the FIFO in that single cycle and go to HOLD.
REQ-018 In HOLD, the FSM SHALL stay until all readN are low, then go to IDLE, so each strobe assertion gives exactly one sample.
REQ-019 If the latched strobe drops during SETTLE, the FSM SHALL return to IDLE without a push.
REQ-020 If more than one readN is high in IDLE, the FSM SHALL stay in IDLE and set strobe_err.
REQ-021 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-022 Otherwise a push SHALL be dropped and overflow SHALL be set.
REQ-023 A pop SHALL occur when out_valid and out_ready are both high; out_data and out_row SHALL show the head combinationally from the FIFO storage.
REQ-024 A push into an empty FIFO SHALL make out_valid high on the next cycle (push-to-valid latency of 1 cycle).
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; a separate count SHALL distinguish full from empty.
REQ-026 frame_done SHALL pulse in the cycle after an accepted or dropped row-3 push.
REQ-027 A convert rising edge SHALL clear overflow and strobe_err; the FIFO contents SHALL be kept.
REQ-028 While out_valid is high and out_ready is low, out_data and out_row SHALL stay stable.

Reset
REQ-029 Reset assertion SHALL, asynchronously, put the FSM in IDLE and clear the pointers, the count and the settle counter.
REQ-030 Reset assertion SHALL, asynchronously, force out_valid=0, frame_done=0, overflow=0 and strobe_err=0.
REQ-031 out_data and out_row SHALL read 0 while the FIFO is empty after reset.
REQ-032 Reset mid-capture SHALL discard the in-flight sample; after release, a strobe still held high SHALL NOT be sampled until it has dropped.

Configuration
REQ-033 With PIXEL_READOUT_ROWCHK_EN defined, the block SHALL track the expected row (0 after reset or a convert rise, +1 per sample).
REQ-034 With PIXEL_READOUT_ROWCHK_EN defined, a sample whose row differs from the expected row SHALL set strobe_err and still be pushed.
REQ-035 Without PIXEL_READOUT_ROWCHK_EN, there SHALL be no row-order tracking, and strobe_err SHALL report only multi-strobe events.

Verification
REQ-036 SETTLE_CYCLES=2, out_ready=1; pulse read1..read4 for 4 cycles each with DATA=0x11,0x22,0x33,0x44 -> four out_valid beats (row0/0x11 .. row3/0x44) and one frame_done pulse.
REQ-037 out_ready=0; five strobes with FIFO_DEPTH=4 -> four entries held, overflow=1, first four values popped in order once out_ready=1.
REQ-038 FIFO full with out_ready=1 in the same cycle as SAMPLE -> the push is accepted, the count stays 4 and overflow stays 0.
REQ-039 read2 and read3 high together -> no push and strobe_err=1; a convert rising edge then clears strobe_err.
REQ-040 read1 dropped after 1 cycle (SETTLE_CYCLES=2) -> no push; reset asserted in SETTLE with read1 held high -> no push until read1 falls and rises again.
REQ-041 With PIXEL_READOUT_ROWCHK_EN defined, strobes in order read1, read3 -> both pushed and strobe_err=1 after the read3 sample.
